dmux8way16_buf: RTL and testbench

Buffered 8-way, 16-bit demultiplexer: the write-side counterpart of `Mux8Way16`. It steers a single 16-bit input stream into one of eight registered output channels (a..h). Each channel holds its word and a valid flag until the downstream consumer acknowledges it. It is the distribution stage that feeds the eight-lane selector path, with a valid/ready input handshake and an optional round-robin addressing mode.

---
 rtl/dmux8way16_buf.sv | 88 ++++++++
 tb/tb_dmux8way16_buf.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmux8way16_buf.sv
// Buffered 8-way, 16-bit demultiplexer. Steers one input stream into eight
// registered channels, each holding its word and a valid flag until acked.
// Destination comes from `sel` or, in auto mode, from a round-robin pointer.
module dmux8way16_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  sel,
    input  logic        auto,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic [15:0] out_c,
    output logic [15:0] out_d,
    output logic [15:0] out_e,
    output logic [15:0] out_f,
    output logic [15:0] out_g,
    output logic [15:0] out_h,
    output logic [7:0]  valid,
    input  logic [7:0]  ack,
    output logic [2:0]  ptr,
    output logic        full,
    output logic        empty
);

    logic [15:0] data_q [8];
    logic [15:0] data_d [8];
    logic [7:0]  valid_q, valid_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [2:0]  dest;
    logic        accept;

    // Destination select and input handshake; an ack on the target frees it now
    always_comb begin
        dest     = auto ? ptr_q : sel;
        in_ready = ~valid_q[dest] | ack[dest];
        accept   = in_valid & in_ready;
    end

    // Next state: acks clear flags, then an accepted write overrides its channel
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~ack;
        ptr_d   = ptr_q;
        if (accept) begin
            data_d[dest]  = in;
            valid_d[dest] = 1'b1;
            if (auto) begin
                ptr_d = ptr_q + 3'd1;
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
            ptr_q   <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= data_d[i];
            end
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    // Output mapping and occupancy flags
    always_comb begin
        out_a = data_q[0];
        out_b = data_q[1];
        out_c = data_q[2];
        out_d = data_q[3];
        out_e = data_q[4];
        out_f = data_q[5];
        out_g = data_q[6];
        out_h = data_q[7];
        valid = valid_q;
        ptr   = ptr_q;
        full  = &valid_q;
        empty = ~|valid_q;
    end

endmodule

// File: tb/tb_dmux8way16_buf.sv
// Self-checking bench for dmux8way16_buf: directed scenarios plus random
// traffic, all compared against a behavioural channel model.
module tb_dmux8way16_buf;

    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  sel;
    logic        auto;
    logic [15:0] out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h;
    logic [7:0]  valid;
    logic [7:0]  ack;
    logic [2:0]  ptr;
    logic        full;
    logic        empty;

    logic [15:0] outs [8];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: plain arrays and integer pointer
    logic [15:0] m_data [8];
    bit          m_valid [8];
    int          m_ptr;

    dmux8way16_buf dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .auto     (auto),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_c    (out_c),
        .out_d    (out_d),
        .out_e    (out_e),
        .out_f    (out_f),
        .out_g    (out_g),
        .out_h    (out_h),
        .valid    (valid),
        .ack      (ack),
        .ptr      (ptr),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        outs[0] = out_a;
        outs[1] = out_b;
        outs[2] = out_c;
        outs[3] = out_d;
        outs[4] = out_e;
        outs[5] = out_f;
        outs[6] = out_g;
        outs[7] = out_h;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_data[i]  = 16'h0;
            m_valid[i] = 1'b0;
        end
        m_ptr = 0;
    endfunction

    function automatic int model_dest(input logic a, input logic [2:0] s);
        return a ? m_ptr : int'(s);
    endfunction

    function automatic bit model_ready(input logic a, input logic [2:0] s, input logic [7:0] k);
        int d;
        d = model_dest(a, s);
        return !m_valid[d] || k[d];
    endfunction

    function automatic void model_step(input logic [15:0] d, input logic v, input logic [2:0] s,
                                       input logic a, input logic [7:0] k);
        int  dst;
        bit  rdy;
        dst = model_dest(a, s);
        rdy = model_ready(a, s, k);
        for (int i = 0; i < 8; i++) begin
            if (k[i]) m_valid[i] = 1'b0;
        end
        if (v && rdy) begin
            m_data[dst]  = d;
            m_valid[dst] = 1'b1;
            if (a) m_ptr = (m_ptr + 1) % 8;
        end
    endfunction

    task automatic check_state();
        int cnt;
        int vec;
        cnt = 0;
        vec = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_valid[i]) begin
                cnt++;
                vec += (1 << i);
            end
            check($sformatf("out[%0d]", i), int'(outs[i]), int'(m_data[i]));
        end
        check("valid", int'(valid), vec);
        check("ptr", int'(ptr), m_ptr);
        check("full", int'(full), (cnt == 8) ? 1 : 0);
        check("empty", int'(empty), (cnt == 0) ? 1 : 0);
    endtask

    // One clock of traffic, entered and left at the falling edge
    task automatic do_cycle(input logic [15:0] d, input logic v, input logic [2:0] s,
                            input logic a, input logic [7:0] k);
        in       = d;
        in_valid = v;
        sel      = s;
        auto     = a;
        ack      = k;
        #1;
        check("in_ready", int'(in_ready), int'(model_ready(a, s, k)));
        @(posedge clk);
        model_step(d, v, s, a, k);
        @(negedge clk);
        check_state();
        in_valid = 1'b0;
        ack      = 8'h00;
    endtask

    // Assert reset between edges while a word is offered; it must not land
    task automatic do_reset();
        reset    = 1'b1;
        in       = 16'hBEEF;
        in_valid = 1'b1;
        sel      = 3'd1;
        #1;
        model_reset();
        check_state();
        check("in_ready_rst", int'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        check_state();
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in       = 16'h0;
        in_valid = 1'b0;
        sel      = 3'd0;
        auto     = 1'b0;
        ack      = 8'h00;
        model_reset();
        @(negedge clk);
        check_state();
        check("in_ready_init", int'(in_ready), 1);
        reset = 1'b0;

        // Manual fill
        do_cycle(16'd246, 1'b1, 3'd0, 1'b0, 8'h00);
        for (int i = 1; i < 8; i++) begin
            do_cycle(16'(i + 1), 1'b1, 3'(i), 1'b0, 8'h00);
        end
        check("fill_a", int'(out_a), 246);
        check("fill_h", int'(out_h), 8);
        check("fill_valid", int'(valid), 8'hFF);
        check("fill_full", int'(full), 1);
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            #1;
            check($sformatf("full_ready[%0d]", i), int'(in_ready), 0);
        end

        // Backpressure, then same-cycle ack lets the write through
        do_cycle(16'd1, 1'b1, 3'd0, 1'b0, 8'h00);
        check("bp_out_a", int'(out_a), 246);
        do_cycle(16'd1, 1'b1, 3'd0, 1'b0, 8'h01);
        check("bp_ack_out_a", int'(out_a), 1);
        check("bp_ack_valid", int'(valid), 8'hFF);

        // Ack-only, twice
        do_cycle(16'd0, 1'b0, 3'd0, 1'b0, 8'hA5);
        check("ackonly_valid", int'(valid), 8'h5A);
        do_cycle(16'd0, 1'b0, 3'd0, 1'b0, 8'hA5);
        check("ackonly_again", int'(valid), 8'h5A);
        check("ackonly_b", int'(out_b), 2);

        // Round-robin wrap with streaming acks
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            check($sformatf("rr_ptr_before[%0d]", i), int'(ptr), (i - 1) % 8);
            do_cycle(16'(i), 1'b1, 3'd0, 1'b1, 8'hFF);
        end
        check("rr_a", int'(out_a), 9);
        check("rr_b", int'(out_b), 10);
        check("rr_c", int'(out_c), 3);
        check("rr_ptr", int'(ptr), 2);

        // Mode switch keeps the pointer
        do_cycle(16'd33, 1'b1, 3'd0, 1'b1, 8'h00);
        check("ms_ptr3", int'(ptr), 3);
        do_cycle(16'd7, 1'b1, 3'd6, 1'b0, 8'h00);
        check("ms_out_g", int'(out_g), 7);
        check("ms_ptr_hold", int'(ptr), 3);
        do_cycle(16'd5, 1'b1, 3'd0, 1'b1, 8'h00);
        check("ms_out_d", int'(out_d), 5);
        check("ms_ptr4", int'(ptr), 4);

        // Reset mid-operation from valid=3C, ptr=5
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_cycle(16'(16'h100 + i), 1'b1, 3'd0, 1'b1, 8'h00);
        end
        do_cycle(16'h1234, 1'b1, 3'd5, 1'b0, 8'h03);
        check("pre_rst_valid", int'(valid), 8'h3C);
        check("pre_rst_ptr", int'(ptr), 5);
        do_reset();
        check("post_rst_empty", int'(empty), 1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 60) == 0) begin
                do_reset();
            end else begin
                do_cycle(16'($urandom), 1'($urandom_range(0, 3) != 0), 3'($urandom),
                         1'($urandom), 8'($urandom & $urandom & $urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
